// File: rtl/huff_region_sched.sv
// rtl/huff_region_sched.sv - big_values Huffman pair sequencer feeding a shared table-decoder bank
// Picks the table per pair from the region boundaries, forwards bits one at a time, and writes each decoded pair.
module huff_region_sched #(
  parameter int VAL_W       = 16,
  parameter int MAX_CW_BITS = 48,
  parameter int MAX_PAIRS   = 288
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [8:0]       cfg_big_values,
  input  logic [8:0]       cfg_region1_start,
  input  logic [8:0]       cfg_region2_start,
  input  logic [4:0]       cfg_table_sel0,
  input  logic [4:0]       cfg_table_sel1,
  input  logic [4:0]       cfg_table_sel2,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  output logic             dec_restart,
  output logic [4:0]       dec_table,
  output logic             dec_valid,
  output logic             dec_data,
  input  logic             dec_done,
  input  logic [VAL_W-1:0] dec_x,
  input  logic [VAL_W-1:0] dec_y,
  output logic             out_valid,
  output logic [8:0]       out_pair_idx,
  output logic [VAL_W-1:0] out_x,
  output logic [VAL_W-1:0] out_y,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int               CNT_W        = $clog2(MAX_CW_BITS + 1);
  localparam logic [CNT_W-1:0] LP_MAX_BITS  = CNT_W'(MAX_CW_BITS);
  localparam logic [8:0]       LP_MAX_PAIRS = 9'(MAX_PAIRS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ZERO,
    S_BIT,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [8:0]       r_bv;
  logic [8:0]       r_r1;
  logic [8:0]       r_r2;
  logic [4:0]       r_sel0;
  logic [4:0]       r_sel1;
  logic [4:0]       r_sel2;
  logic [8:0]       r_p;
  logic [CNT_W-1:0] r_bitcnt;
  logic [4:0]       r_dec_table;
  logic             r_out_valid;
  logic [8:0]       r_out_idx;
  logic [VAL_W-1:0] r_out_x;
  logic [VAL_W-1:0] r_out_y;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [4:0]       w_sel;
  logic             w_last;
  logic             w_cfg_bad;
  logic             w_cfg_empty;
  logic             w_timeout;

  // An empty or inverted region simply never wins the comparison chain.
  assign w_sel       = (r_p < r_r1) ? r_sel0 : ((r_p < r_r2) ? r_sel1 : r_sel2);
  assign w_last      = ({1'b0, r_p} + 10'd1) == {1'b0, r_bv};
  assign w_cfg_bad   = cfg_big_values > LP_MAX_PAIRS;
  assign w_cfg_empty = cfg_big_values == 9'd0;
  assign w_timeout   = r_bitcnt == LP_MAX_BITS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    in_ready    = 1'b0;
    dec_valid   = 1'b0;
    dec_data    = 1'b0;
    dec_restart = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !w_cfg_bad) begin
          w_next = w_cfg_empty ? S_FINISH : S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_sel == 5'd0) begin
          w_next = S_ZERO;
        end else begin
          dec_restart = 1'b1;
          w_next      = S_BIT;
        end
      end
      S_ZERO: begin
        w_next = w_last ? S_FINISH : S_SETUP;
      end
      S_BIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dec_valid = 1'b1;
          dec_data  = in_data;
          w_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dec_done) begin
          w_next = w_last ? S_FINISH : S_SETUP;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_BIT;
        end
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bv        <= 9'd0;
      r_r1        <= 9'd0;
      r_r2        <= 9'd0;
      r_sel0      <= 5'd0;
      r_sel1      <= 5'd0;
      r_sel2      <= 5'd0;
      r_p         <= 9'd0;
      r_bitcnt    <= '0;
      r_dec_table <= 5'd0;
      r_out_valid <= 1'b0;
      r_out_idx   <= 9'd0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_bad) begin
              r_err <= 1'b1;
            end else begin
              r_bv   <= cfg_big_values;
              r_r1   <= cfg_region1_start;
              r_r2   <= cfg_region2_start;
              r_sel0 <= cfg_table_sel0;
              r_sel1 <= cfg_table_sel1;
              r_sel2 <= cfg_table_sel2;
              r_p    <= 9'd0;
              r_busy <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          r_dec_table <= w_sel;
          r_bitcnt    <= '0;
        end
        S_ZERO: begin
          r_out_valid <= 1'b1;
          r_out_idx   <= r_p;
          r_out_x     <= '0;
          r_out_y     <= '0;
          if (!w_last) begin
            r_p <= r_p + 9'd1;
          end
        end
        S_BIT: begin
          if (in_valid) begin
            r_bitcnt <= r_bitcnt + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (dec_done) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= r_p;
            r_out_x     <= dec_x;
            r_out_y     <= dec_y;
            if (!w_last) begin
              r_p <= r_p + 9'd1;
            end
          end else if (w_timeout) begin
            r_err  <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        S_FINISH: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign dec_table    = r_dec_table;
  assign out_valid    = r_out_valid;
  assign out_pair_idx = r_out_idx;
  assign out_x        = r_out_x;
  assign out_y        = r_out_y;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_huff_region_sched.sv
// tb/tb_huff_region_sched.sv - bench for huff_region_sched
// Vector table plus hand sequences and random granules against a pair-level reference model.
module tb_huff_region_sched;
  localparam int VAL_W = 16;
  localparam logic [22:0] CW17 = 23'b00011000100000100101011;
  localparam int M_NORMAL = 0;
  localparam int M_SINGLE = 1;
  localparam int M_NEVER  = 2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [8:0] cfg_big_values, cfg_region1_start, cfg_region2_start;
  logic [4:0] cfg_table_sel0, cfg_table_sel1, cfg_table_sel2;
  logic in_valid, in_data, in_ready;
  logic dec_restart, dec_valid, dec_data, dec_done;
  logic [4:0] dec_table;
  logic [VAL_W-1:0] dec_x, dec_y, out_x, out_y;
  logic out_valid, busy, done, err;
  logic [8:0] out_pair_idx;

  always #5 clk = ~clk;

  huff_region_sched #(.VAL_W(VAL_W), .MAX_CW_BITS(48), .MAX_PAIRS(288)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_big_values(cfg_big_values), .cfg_region1_start(cfg_region1_start),
    .cfg_region2_start(cfg_region2_start), .cfg_table_sel0(cfg_table_sel0),
    .cfg_table_sel1(cfg_table_sel1), .cfg_table_sel2(cfg_table_sel2),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dec_restart(dec_restart), .dec_table(dec_table), .dec_valid(dec_valid),
    .dec_data(dec_data), .dec_done(dec_done), .dec_x(dec_x), .dec_y(dec_y),
    .out_valid(out_valid), .out_pair_idx(out_pair_idx), .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [8:0]       idx;
    logic [VAL_W-1:0] x;
    logic [VAL_W-1:0] y;
  } pair_t;

  typedef struct {
    string name;
    int bv, r1, r2, s0, s1, s2, mode;
    int outs, restarts, dn, er;
  } vec_t;

  pair_t outq[$], exp_outq[$];
  logic [4:0] tblq[$], exp_tblq[$];
  logic bitq[$];
  int cyc, restarts, nbits, done_cnt, err_cnt, spacing_err, done_cyc, last_out_cyc, start_cyc;
  int exp_restarts, stub_mode, scnt, passed, total;
  bit busy_seen, ready_seen, hs, pend, prev_dv, gaps, noise;
  logic [63:0] sbits;

  function automatic int stub_len(input logic [4:0] t, input int mode);
    if (mode == M_SINGLE) return 1;
    if (t == 5'd17) return 23;
    return (int'(t) % 7) + 1;
  endfunction

  // Decoder bank stand-in: the real HT_17 answer for the reference codeword, a bit-derived value otherwise.
  function automatic void dec_fn(input logic [4:0] t, input logic [63:0] b, input int n,
                                 output logic [VAL_W-1:0] x, output logic [VAL_W-1:0] y);
    if (t == 5'd17 && n == 23 && b[22:0] == CW17) begin
      x = VAL_W'(7);
      y = VAL_W'(-9);
    end else begin
      x = VAL_W'({t, b[10:0]});
      y = VAL_W'(b[15:0] ^ 16'h5A3C);
    end
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  initial begin : drv
    in_valid = 0; in_data = 0; dec_done = 0; dec_x = '0; dec_y = '0;
    hs = 0; pend = 0; prev_dv = 0; scnt = 0; sbits = '0; cyc = 0;
    forever begin
      @(negedge clk);
      if (hs && bitq.size() > 0) void'(bitq.pop_front());
      if (bitq.size() == 0) in_valid = 1'b0;
      else if (hs || !in_valid) in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = in_valid ? bitq[0] : 1'($urandom_range(0, 1));
      #1;
      cyc++;
      hs = in_valid && in_ready;
      if (pend && stub_mode != M_NEVER && scnt == stub_len(dec_table, stub_mode)) begin
        dec_done = 1'b1;
        dec_fn(dec_table, sbits, scnt, dec_x, dec_y);
      end else if (noise && !pend) begin
        dec_done = 1'($urandom_range(0, 1));
        dec_x = VAL_W'($urandom);
        dec_y = VAL_W'($urandom);
      end else begin
        dec_done = 1'b0;
      end
      pend = dec_valid;
      if (dec_restart) begin scnt = 0; sbits = '0; restarts++; end
      if (dec_valid) begin
        scnt++;
        sbits = {sbits[62:0], dec_data};
        tblq.push_back(dec_table);
        nbits++;
        if (prev_dv) spacing_err++;
      end
      prev_dv = dec_valid;
      if (out_valid) begin
        pair_t o;
        o.idx = out_pair_idx; o.x = out_x; o.y = out_y;
        outq.push_back(o);
        last_out_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) err_cnt++;
      if (busy) busy_seen = 1;
      if (in_ready) ready_seen = 1;
    end
  end

  task automatic clear_obs();
    outq.delete(); tblq.delete();
    restarts = 0; nbits = 0; done_cnt = 0; err_cnt = 0; spacing_err = 0;
    busy_seen = 0; ready_seen = 0; done_cyc = -1; last_out_cyc = -1;
  endtask

  task automatic build_model(input int bv, r1, r2, s0, s1, s2, mode);
    exp_outq.delete(); exp_tblq.delete(); bitq.delete(); exp_restarts = 0;
    if (bv == 0 || bv > 288) return;
    for (int p = 0; p < bv; p++) begin
      logic [4:0] t;
      logic [63:0] b;
      int n;
      pair_t e;
      t = (p < r1) ? 5'(s0) : ((p < r2) ? 5'(s1) : 5'(s2));
      e.idx = 9'(p);
      if (t == 5'd0) begin
        e.x = '0; e.y = '0;
        exp_outq.push_back(e);
        continue;
      end
      exp_restarts++;
      if (mode == M_NEVER) begin
        for (int i = 0; i < 60; i++) bitq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < 48; i++) exp_tblq.push_back(t);
        return;
      end
      n = stub_len(t, mode);
      b = (t == 5'd17 && p % 2 == 0) ? 64'(CW17) : {$urandom, $urandom};
      b = b & ((64'd1 << n) - 64'd1);
      for (int i = n - 1; i >= 0; i--) begin
        bitq.push_back(b[i]);
        exp_tblq.push_back(t);
      end
      dec_fn(t, b, n, e.x, e.y);
      exp_outq.push_back(e);
    end
  endtask

  task automatic start_granule(input int bv, r1, r2, s0, s1, s2);
    @(negedge clk);
    start = 1'b1;
    cfg_big_values = 9'(bv); cfg_region1_start = 9'(r1); cfg_region2_start = 9'(r2);
    cfg_table_sel0 = 5'(s0); cfg_table_sel1 = 5'(s1); cfg_table_sel2 = 5'(s2);
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    cfg_big_values = 9'($urandom); cfg_region1_start = 9'($urandom);
    cfg_region2_start = 9'($urandom); cfg_table_sel0 = 5'($urandom);
    cfg_table_sel1 = 5'($urandom); cfg_table_sel2 = 5'($urandom);
  endtask

  task automatic wait_end(input string nm);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk); #2;
      if (done_cnt + err_cnt > 0) break;
    end
    check({nm, " ended in budget"}, k < 5000, 1);
    repeat (4) @(negedge clk);
    #2;
    check({nm, " idle after"}, {busy, in_ready}, 0);
  endtask

  task automatic cmp_streams(input string nm);
    int mi;
    check({nm, " pair count"}, outq.size(), exp_outq.size());
    mi = -1;
    for (int i = 0; i < outq.size() && i < exp_outq.size(); i++)
      if (mi < 0 && (outq[i].idx != exp_outq[i].idx || outq[i].x != exp_outq[i].x ||
                     outq[i].y != exp_outq[i].y)) mi = i;
    check({nm, " first bad pair"}, mi, -1);
    check({nm, " bit count"}, tblq.size(), exp_tblq.size());
    mi = -1;
    for (int i = 0; i < tblq.size() && i < exp_tblq.size(); i++)
      if (mi < 0 && tblq[i] != exp_tblq[i]) mi = i;
    check({nm, " first bad dec_table"}, mi, -1);
    check({nm, " bit spacing"}, spacing_err, 0);
  endtask

  initial begin : wdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t vt[9];
    int k;
    vt[0] = '{"t17_single", 1, 1, 1, 17, 0, 0, M_NORMAL, 1, 1, 1, 0};
    vt[1] = '{"t0_region", 4, 2, 4, 0, 17, 5, M_NORMAL, 4, 2, 1, 0};
    vt[2] = '{"region_sw", 3, 1, 2, 1, 2, 3, M_SINGLE, 3, 3, 1, 0};
    vt[3] = '{"bv_289", 289, 1, 2, 1, 2, 3, M_NORMAL, 0, 0, 0, 1};
    vt[4] = '{"bv_0", 0, 1, 2, 1, 2, 3, M_NORMAL, 0, 0, 1, 0};
    vt[5] = '{"timeout", 2, 2, 2, 4, 1, 1, M_NEVER, 0, 1, 0, 1};
    vt[6] = '{"r2_lt_r1", 6, 4, 2, 0, 9, 3, M_NORMAL, 6, 2, 1, 0};
    vt[7] = '{"r_beyond", 5, 7, 9, 6, 1, 2, M_NORMAL, 5, 5, 1, 0};
    vt[8] = '{"max_zero", 288, 100, 200, 0, 0, 0, M_NORMAL, 288, 0, 1, 0};

    passed = 0; total = 0; stub_mode = M_NORMAL; gaps = 0; noise = 0;
    rst = 1'b1; start = 1'b0;
    cfg_big_values = 0; cfg_region1_start = 0; cfg_region2_start = 0;
    cfg_table_sel0 = 0; cfg_table_sel1 = 0; cfg_table_sel2 = 0;
    clear_obs();
    repeat (3) @(negedge clk);
    #2;
    check("reset outputs", {in_ready, dec_restart, dec_table, dec_valid, dec_data, out_valid,
                            out_pair_idx, out_x, out_y, busy, done, err}, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      clear_obs();
      stub_mode = vt[i].mode; noise = 0; gaps = (i % 2 == 1);
      build_model(vt[i].bv, vt[i].r1, vt[i].r2, vt[i].s0, vt[i].s1, vt[i].s2, vt[i].mode);
      start_granule(vt[i].bv, vt[i].r1, vt[i].r2, vt[i].s0, vt[i].s1, vt[i].s2);
      wait_end(vt[i].name);
      check({vt[i].name, " outs"}, outq.size(), vt[i].outs);
      check({vt[i].name, " restarts"}, restarts, vt[i].restarts);
      check({vt[i].name, " done"}, done_cnt, vt[i].dn);
      check({vt[i].name, " err"}, err_cnt, vt[i].er);
      cmp_streams(vt[i].name);
      if (vt[i].bv == 1) check({vt[i].name, " done delay"}, done_cyc - last_out_cyc, 1);
      if (vt[i].bv == 0) check({vt[i].name, " done delay"}, done_cyc - start_cyc, 2);
      if (vt[i].bv > 288) check({vt[i].name, " busy seen"}, busy_seen, 0);
      if (vt[i].mode == M_NEVER) check({vt[i].name, " bits before err"}, nbits, 48);
      if (vt[i].restarts == 0 && vt[i].outs > 0) check({vt[i].name, " in_ready seen"}, ready_seen, 0);
    end

    // start while busy must not disturb the running granule
    clear_obs();
    stub_mode = M_SINGLE; gaps = 1;
    build_model(3, 1, 2, 1, 2, 3, M_SINGLE);
    start_granule(3, 1, 2, 1, 2, 3);
    start_granule(5, 0, 0, 0, 0, 0);
    wait_end("restart_ignored");
    check("restart_ignored done", done_cnt, 1);
    cmp_streams("restart_ignored");

    // asynchronous reset in the middle of pair 1
    clear_obs();
    stub_mode = M_NORMAL; gaps = 0;
    build_model(3, 3, 3, 17, 0, 0, M_NORMAL);
    start_granule(3, 3, 3, 17, 0, 0);
    for (k = 0; k < 3000; k++) begin
      @(negedge clk); #2;
      if (nbits >= 33) break;
    end
    check("mid reset reached bit", nbits, 33);
    check("mid reset pair0 held", out_x, 7);
    rst = 1'b1;
    #1;
    check("mid reset outputs", {in_ready, dec_restart, dec_table, dec_valid, dec_data, out_valid,
                                out_pair_idx, out_x, out_y, busy, done, err}, 0);
    repeat (3) @(negedge clk);
    check("mid reset no pulses", done_cnt + err_cnt, 0);
    bitq.delete();
    rst = 1'b0;
    clear_obs();
    build_model(2, 1, 2, 17, 5, 0, M_NORMAL);
    start_granule(2, 1, 2, 17, 5, 0);
    wait_end("after_reset");
    check("after_reset done", done_cnt, 1);
    cmp_streams("after_reset");

    // random granules with idle-time dec_done noise and bursty input
    for (int g = 0; g < 25; g++) begin
      int bv, r1, r2, s0, s1, s2;
      bv = $urandom_range(1, 14);
      r1 = $urandom_range(0, 16);
      r2 = $urandom_range(0, 16);
      s0 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      s1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      s2 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      clear_obs();
      stub_mode = M_NORMAL; noise = 1; gaps = 1;
      build_model(bv, r1, r2, s0, s1, s2, M_NORMAL);
      start_granule(bv, r1, r2, s0, s1, s2);
      wait_end($sformatf("rnd%0d", g));
      check($sformatf("rnd%0d done", g), done_cnt, 1);
      check($sformatf("rnd%0d err", g), err_cnt, 0);
      check($sformatf("rnd%0d restarts", g), restarts, exp_restarts);
      cmp_streams($sformatf("rnd%0d", g));
    end
    noise = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
